// File: rtl/anode_scan_controller.sv
// Purpose : four-digit seven-segment scan sequencer with guard slots and scrolling message index.
// Latency : anode/blank/digit_sel/msg_index decode combinationally from registered phase; scan_done/scroll_step are registered (one clk after the wrapping tick).
// Backpressure: none; enable=0 freezes all counters and blanks the display.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        synchronous active-high clear of all state
//   enable       1 = scanning runs, 0 = freeze counters and blank anodes
//   scroll_en    1 = advance the scroll offset once every SCROLL_SCANS full scans
//   anode[3:0]   active-low digit enables, anode[0] = rightmost digit
//   digit_sel    digit addressed by the current phase (0..3)
//   msg_index    message-buffer index for digit_sel, (offset + digit_sel) mod 16
//   blank        1 = all anodes are off this cycle
//   scan_done    one-cycle pulse after a full 16-phase scan completes
//   scroll_step  one-cycle pulse when the scroll offset advances
//
// Each digit owns four consecutive phase slots: setup (blank), two lit slots,
// and hold (blank). The blank slots on both sides of a digit guarantee that
// adjacent digits are never driven in the same cycle and give the message ROM
// and segment decoder a full slot of setup time before a digit lights.

module anode_scan_controller #(
   parameter int PRESCALE     = 4,
   parameter int SCROLL_SCANS = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       scroll_en,
   output logic [3:0] anode,
   output logic [1:0] digit_sel,
   output logic [3:0] msg_index,
   output logic       blank,
   output logic       scan_done,
   output logic       scroll_step
);

   // Counter widths; a count range of one still needs a 1-bit register.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SW = (SCROLL_SCANS > 1) ? $clog2(SCROLL_SCANS) : 1;

   localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
   localparam logic [SW-1:0] SCAN_LAST     = SW'(SCROLL_SCANS - 1);
   localparam logic [3:0]    PHASE_LAST    = 4'hF;

   // Slot types within a digit, decoded from phase[1:0].
   localparam logic [1:0] SLOT_SETUP = 2'b00;
   localparam logic [1:0] SLOT_LIT_A = 2'b01;
   localparam logic [1:0] SLOT_LIT_B = 2'b10;
   localparam logic [1:0] SLOT_HOLD  = 2'b11;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PW-1:0] prescaler;
   logic [3:0]    phase;
   logic [SW-1:0] scan_cnt;
   logic [3:0]    offset;

   logic          tick;
   logic          scan_wrap;
   logic          scan_last;
   logic          scroll_now;

   // A tick only exists while enabled, so every pulse and counter below is
   // automatically frozen when enable is low.
   assign tick       = enable && (prescaler == PRESCALE_LAST);
   assign scan_wrap  = tick && (phase == PHASE_LAST);
   assign scan_last  = (scan_cnt == SCAN_LAST);
   assign scroll_now = scan_wrap && scan_last && scroll_en;

   // ------------------------------------------------------------------
   // Prescaler and phase
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler <= '0;
         phase     <= '0;
      end else if (enable) begin
         if (tick) begin
            prescaler <= '0;
            phase     <= phase + 4'd1;   // 15 wraps naturally to 0
         end else begin
            prescaler <= prescaler + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Scan counter and scroll offset
   // ------------------------------------------------------------------
   // scan_cnt keeps counting with scroll_en low, so re-enabling scroll waits
   // for the next natural scan_cnt wrap instead of stepping immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt <= '0;
         offset   <= '0;
      end else if (scan_wrap) begin
         if (scan_last) begin
            scan_cnt <= '0;
            if (scroll_en) begin
               offset <= offset + 4'd1;
            end
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registered event pulses
   // ------------------------------------------------------------------
   // Both pulses are cleared by reset on the same edge, so a wrap coinciding
   // with reset never produces a pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_done   <= 1'b0;
         scroll_step <= 1'b0;
      end else begin
         scan_done   <= scan_wrap;
         scroll_step <= scroll_now;
      end
   end

   // ------------------------------------------------------------------
   // Phase decode
   // ------------------------------------------------------------------
   logic slot_lit;

   always_comb begin
      slot_lit = 1'b0;
      case (phase[1:0])
         SLOT_LIT_A: slot_lit = 1'b1;
         SLOT_LIT_B: slot_lit = 1'b1;
         SLOT_SETUP: slot_lit = 1'b0;
         SLOT_HOLD:  slot_lit = 1'b0;
         default:    slot_lit = 1'b0;
      endcase
   end

   // digit_sel and msg_index follow the held phase even while disabled so
   // the downstream ROM output stays stable across a freeze.
   assign digit_sel = phase[3:2];
   assign msg_index = offset + {2'b00, digit_sel};

   always_comb begin
      anode = 4'b1111;
      blank = 1'b1;
      if (enable && slot_lit) begin
         blank = 1'b0;
         anode = ~(4'b0001 << digit_sel);
      end
   end

endmodule

// File: tb/tb_anode_scan_controller.sv
// Purpose : directed bench for anode_scan_controller (PRESCALE=4, SCROLL_SCANS=2).
// Latency : every clock the expected output word is queued before the edge and compared 1 ns after it.
// Backpressure: none.

module tb_anode_scan_controller;

   localparam int PRESCALE     = 4;
   localparam int SCROLL_SCANS = 2;
   localparam int CLKS_PER_SCAN = 16 * PRESCALE;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       scroll_en;
   logic [3:0] anode;
   logic [1:0] digit_sel;
   logic [3:0] msg_index;
   logic       blank;
   logic       scan_done;
   logic       scroll_step;

   anode_scan_controller #(
      .PRESCALE     (PRESCALE),
      .SCROLL_SCANS (SCROLL_SCANS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .scroll_en   (scroll_en),
      .anode       (anode),
      .digit_sel   (digit_sel),
      .msg_index   (msg_index),
      .blank       (blank),
      .scan_done   (scan_done),
      .scroll_step (scroll_step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] anode;
      logic       blank;
      logic [1:0] digit_sel;
      logic [3:0] msg_index;
      logic       scan_done;
      logic       scroll_step;
   } obs_t;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Time-based reference: n counts enabled, non-reset clock edges since the
   // last reset; everything else is derived from n and the scroll history.
   int unsigned n    = 0;
   logic [3:0]  off  = 4'd0;
   obs_t        sb_q[$];

   function automatic logic [3:0] lit_pattern(input logic [1:0] d);
      case (d)
         2'd0:    lit_pattern = 4'b1110;
         2'd1:    lit_pattern = 4'b1101;
         2'd2:    lit_pattern = 4'b1011;
         default: lit_pattern = 4'b0111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, queue the expected post-edge outputs, then
   // compare the DUT against the head of the queue.
   task automatic cyc(input string tag, input logic r, input logic en, input logic se);
      obs_t        e;
      obs_t        got;
      obs_t        want;
      int unsigned ph;
      logic [1:0]  d;
      logic        lit;
      reset     = r;
      enable    = en;
      scroll_en = se;
      e = '0;
      if (r) begin
         n   = 0;
         off = 4'd0;
      end else if (en) begin
         n++;
         if (n % CLKS_PER_SCAN == 0) begin
            e.scan_done = 1'b1;
            if (((n / CLKS_PER_SCAN) % SCROLL_SCANS == 0) && se) begin
               e.scroll_step = 1'b1;
               off = off + 4'd1;
            end
         end
      end
      ph = (n / PRESCALE) % 16;
      d  = 2'(ph / 4);
      lit = en && ((ph % 4 == 1) || (ph % 4 == 2));
      e.digit_sel = d;
      e.msg_index = off + {2'b00, d};
      e.blank     = !lit;
      e.anode     = lit ? lit_pattern(d) : 4'b1111;
      sb_q.push_back(e);

      @(posedge clk);
      #1;
      got  = '{anode, blank, digit_sel, msg_index, scan_done, scroll_step};
      want = sb_q.pop_front();
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s n=%0d: observed an=%b bl=%b ds=%0d mi=%0d sd=%b ss=%b expected an=%b bl=%b ds=%0d mi=%0d sd=%b ss=%b",
                tag, n, got.anode, got.blank, got.digit_sel, got.msg_index, got.scan_done, got.scroll_step,
                want.anode, want.blank, want.digit_sel, want.msg_index, want.scan_done, want.scroll_step);
      end
   endtask

   task automatic run(input string tag, input int cnt, input logic en, input logic se);
      for (int i = 0; i < cnt; i++) begin
         cyc(tag, 1'b0, en, se);
      end
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      scroll_en = 1'b0;

      // Reset state
      cyc("reset", 1'b1, 1'b0, 1'b0);
      cyc("reset", 1'b1, 1'b1, 1'b1);
      chk("reset_anode", 32'(anode), 32'hF);
      chk("reset_blank", 32'(blank), 32'd1);
      chk("reset_idx",   32'(msg_index), 32'd0);

      // Anode sequence and first scan_done, scroll disabled for 3 scans
      run("scan1", CLKS_PER_SCAN - 1, 1'b1, 1'b0);
      chk("pre_done", 32'(scan_done), 32'd0);
      run("scan1", 1, 1'b1, 1'b0);
      chk("scan_done_64", 32'(scan_done), 32'd1);
      chk("phase0_digit", 32'(digit_sel), 32'd0);
      run("noscroll", 2 * CLKS_PER_SCAN, 1'b1, 1'b0);
      chk("noscroll_off", 32'(msg_index), 32'd0);

      // Scroll re-enabled: steps on scans 4,6,...,32 -> offset 15
      run("scroll", 29 * CLKS_PER_SCAN, 1'b1, 1'b1);
      run("scroll", 12 * PRESCALE, 1'b1, 1'b1);
      chk("digit3_off15_idx", 32'(msg_index), 32'd2);
      chk("digit3_sel", 32'(digit_sel), 32'd3);
      run("scroll", 4 * PRESCALE + CLKS_PER_SCAN, 1'b1, 1'b1);
      chk("off_wrap_idx", 32'(msg_index), 32'd0);

      // Freeze at phase 5 with prescaler=1 for 10 clocks
      cyc("frz_rst", 1'b1, 1'b0, 1'b1);
      run("frz_pre", 5 * PRESCALE + 1, 1'b1, 1'b1);
      chk("frz_lit", 32'(anode), 32'b1101);
      run("frz_off", 10, 1'b0, 1'b1);
      chk("frz_anode", 32'(anode), 32'hF);
      chk("frz_blank", 32'(blank), 32'd1);
      chk("frz_digit", 32'(digit_sel), 32'd1);
      run("frz_resume", 2, 1'b1, 1'b1);
      chk("resume_ph5", 32'(digit_sel), 32'd1);
      run("frz_resume", 1, 1'b1, 1'b1);
      chk("resume_ph6", 32'(anode), 32'b1101);
      run("frz_resume", PRESCALE, 1'b1, 1'b1);
      chk("resume_ph7", 32'(blank), 32'd1);

      // Reset at phase 9, offset 3
      cyc("rst6", 1'b1, 1'b1, 1'b1);
      run("rst6_pre", 6 * CLKS_PER_SCAN + 9 * PRESCALE, 1'b1, 1'b1);
      chk("ph9_idx", 32'(msg_index), 32'd5);
      cyc("rst6_hit", 1'b1, 1'b1, 1'b1);
      chk("rst6_anode", 32'(anode), 32'hF);
      chk("rst6_idx", 32'(msg_index), 32'd0);
      chk("rst6_done", 32'(scan_done), 32'd0);

      // Reset on the edge that would wrap the scan: pulse dropped
      run("pend", CLKS_PER_SCAN - 1, 1'b1, 1'b1);
      cyc("pend_rst", 1'b1, 1'b1, 1'b1);
      chk("pend_done", 32'(scan_done), 32'd0);
      chk("pend_step", 32'(scroll_step), 32'd0);
      run("post", 8, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/anode_scan_controller.md
Name: anode_scan_controller

Overview:
Sequencer for the four-digit seven-segment display. It steps a 4-bit scan phase at a prescaled rate, drives active-low anodes with blanking guard slots between digits, and produces the message-buffer index for each digit. The index scrolls through a 16-character message. The block sits between the board clock and the segment decoder/message ROM in the display datapath.

Parameters:
PRESCALE, 4, clk cycles per phase tick (>=2; the board build overrides it, for example to 2^14).
SCROLL_SCANS, 16, completed full scans per scroll step (>=1).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; clears all state on the next rising clk edge
enable  in  1  1 = scanning runs; 0 = freeze and blank
scroll_en  in  1  1 = advance scroll offset every SCROLL_SCANS scans
anode  out  4  active-low digit enables; anode[0] = rightmost digit
digit_sel  out  2  digit currently addressed (0..3)
msg_index  out  4  message character index for digit_sel
blank  out  1  1 = all anodes off this cycle (segment decoder may output all-off)
scan_done  out  1  one-cycle pulse when a full 16-phase scan completes
scroll_step  out  1  one-cycle pulse when scroll offset advances

Behaviour:
- State registers:
  - prescaler: counts 0..PRESCALE-1.
  - phase: 4 bits.
  - scan_cnt: counts 0..SCROLL_SCANS-1.
  - offset: 4 bits.
- Reset (synchronous, priority over everything): prescaler=0, phase=0, scan_cnt=0, offset=0.
  - Registered pulses scan_done=0, scroll_step=0.
  - Therefore anode=4'b1111, blank=1, digit_sel=0, msg_index=0.
- Tick: asserted internally when enable=1 and prescaler==PRESCALE-1.
  - On tick, prescaler wraps to 0 and phase increments modulo 16 (15 wraps to 0).
  - With enable=1 and no tick, prescaler increments.
- Phase decode (combinational from registered phase, zero added latency):
  - digit_sel = phase[3:2].
  - phase[1:0]=00: setup slot, blank=1.
  - phase[1:0]=11: hold slot, blank=1.
  - phase[1:0]=01 or 10: blank=0 and anode = ~(4'b0001 << digit_sel).
  - Each digit is lit for 2 of its 4 phase slots. Two adjacent digits are never lit in the same cycle.
- msg_index = (offset + digit_sel) mod 16, 4-bit wrap. It is valid throughout the digit's 4 slots, including blank slots, so the ROM has setup time.
- scan_done is registered. It goes high for exactly one cycle in the cycle after the tick that moves phase 15 to 0.
- Scroll, on the same tick that wraps phase 15 to 0:
  - If scan_cnt==SCROLL_SCANS-1: scan_cnt=0. If scroll_en=1, also offset=offset+1 mod 16 and scroll_step pulses high one cycle, aligned with scan_done.
  - Otherwise scan_cnt increments.
- scroll_en=0: scan_cnt still counts and wraps, offset holds, scroll_step stays 0.
- offset wraps 15 to 0. msg_index for digit 3 at offset 14 is 1.
- enable=0:
  - prescaler, phase, scan_cnt and offset all hold.
  - anode forced to 4'b1111 and blank=1 regardless of phase.
  - No scan_done or scroll_step pulses.
  - digit_sel and msg_index keep tracking the held phase.
- enable re-asserted: resumes from the held prescaler value. No phase is skipped or repeated.
- Reset mid-scan: next edge returns to phase 0, offset 0. Any pending pulse is dropped.
- Reset together with enable or scroll_en: reset wins.

Test Plan:
1. Reset then enable=1, PRESCALE=4. Required: phase advances every 4 clks; anode sequence per 16 ticks is 1111, 1110, 1110, 1111, 1111, 1101, 1101, 1111, then the same pattern for 1011 and 0111. blank tracks exactly.
2. Run 16 ticks from reset. Required: scan_done high exactly one clk, 64 clks after reset release; phase=0 and digit_sel=0 afterwards.
3. SCROLL_SCANS=2, scroll_en=1. Required: scroll_step pulses on the 2nd, 4th, ... scan_done. msg_index for digit 3 after 15 steps (offset 15) is 2, i.e. wrap verified.
4. scroll_en=0 for 3 scans, then 1. Required: offset stays 0, no scroll_step. The next step occurs on scan_cnt wrap, not immediately.
5. Drop enable at phase 5 (digit 1 lit) for 10 clks. Required: anode=1111 and blank=1 throughout; on re-enable, phase continues 5 then 6 with the prescaler count preserved.
6. Assert reset at phase 9, offset 3, for one clk. Required: next edge gives anode=1111, phase=0, offset=0, msg_index=0, with no scan_done pulse.
